// File: rtl/viterbi_decoder_param.sv
// viterbi_decoder_param -- hard-decision Viterbi decoder for rate-1/2
// convolutional codes. The survivors use register exchange, and there is one ACS
// unit for each of the 2^(K-1) trellis states.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid             one received symbol this cycle (no backpressure)
//   sof                  with in_valid: this symbol starts a new frame
//   enc_bits[1:0]        received symbol {c0,c1}
//   enc_erase[1:0]       per-bit erasure; an erased bit adds no distance
//   out_valid            single-cycle pulse, out_bit/out_metric valid
//   out_bit              oldest survivor bit of the best state
//   out_metric           normalised metric of that best state

// Per-state add-compare-select. State ST takes its two predecessors
// {ST[K-3:0], x}. The predecessor metrics and survivors come from the top level.
module viterbi_acs #(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6,
  parameter int             ST       = 0
) (
  input  logic [1:0]          enc_bits,
  input  logic [1:0]          enc_erase,
  input  logic [METRIC_W-1:0] pm0,
  input  logic [METRIC_W-1:0] pm1,
  input  logic [TB_DEPTH-1:0] sv0,
  input  logic [TB_DEPTH-1:0] sv1,
  output logic [METRIC_W:0]   cand,
  output logic [TB_DEPTH-1:0] sv_new
);
  localparam logic [K-2:0] S = (K-1)'(ST);

  // Hamming distance between the received symbol and the branch output of
  // the encoder register sr = {u, s}. Erased bits are skipped.
  function automatic logic [1:0] bm(input logic [K-1:0] sr,
                                    input logic [1:0] b, input logic [1:0] e);
    logic d0, d1;
    d0 = ((^(sr & G0)) != b[1]) && !e[1];
    d1 = ((^(sr & G1)) != b[0]) && !e[0];
    return {1'b0, d0} + {1'b0, d1};
  endfunction

  logic [METRIC_W:0] c0, c1;
  logic              u;

  assign u = S[K-2];

  // The candidates carry one extra bit so that the compare cannot alias.
  // A tie keeps predecessor x=0.
  always_comb begin
    c0 = {1'b0, pm0} + (METRIC_W+1)'(bm({S, 1'b0}, enc_bits, enc_erase));
    c1 = {1'b0, pm1} + (METRIC_W+1)'(bm({S, 1'b1}, enc_bits, enc_erase));
    if (c1 < c0) begin
      cand   = c1;
      sv_new = {sv1[TB_DEPTH-2:0], u};
    end else begin
      cand   = c0;
      sv_new = {sv0[TB_DEPTH-2:0], u};
    end
  end
endmodule

module viterbi_decoder_param #(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                sof,
  input  logic [1:0]          enc_bits,
  input  logic [1:0]          enc_erase,
  output logic                out_valid,
  output logic                out_bit,
  output logic [METRIC_W-1:0] out_metric
);
  localparam int                 NS   = 1 << (K-1);
  localparam int                 CW   = $clog2(TB_DEPTH);
  localparam logic [CW-1:0]      LAST = CW'(TB_DEPTH-1);
  localparam logic [METRIC_W-1:0] HALF = {1'b1, {(METRIC_W-1){1'b0}}};

  logic [NS-1:0][METRIC_W-1:0] pm, base_pm, nm;
  logic [NS-1:0][TB_DEPTH-1:0] sv, base_sv, nsv;
  logic [NS-1:0][METRIC_W:0]   cand;
  logic [CW-1:0]               cnt, idx;
  logic                        all_hi, best_bit;
  logic [METRIC_W-1:0]         best_m;

  // A start-of-frame symbol runs ACS from the reset trellis state, so the
  // stored state of the old frame never feeds into the new frame.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      base_pm[i] = sof ? ((i == 0) ? '0 : HALF) : pm[i];
      base_sv[i] = sof ? '0 : sv[i];
    end
  end

  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int P0 = (2*n) % NS;
    viterbi_acs #(
      .K(K), .G0(G0), .G1(G1), .TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W), .ST(n)
    ) u_acs (
      .enc_bits (enc_bits),
      .enc_erase(enc_erase),
      .pm0      (base_pm[P0]),
      .pm1      (base_pm[P0+1]),
      .sv0      (base_sv[P0]),
      .sv1      (base_sv[P0+1]),
      .cand     (cand[n]),
      .sv_new   (nsv[n])
    );
  end

  // Normalisation happens when every new metric has reached the top half.
  // The spread between metrics stays bounded, so removing HALF keeps every
  // metric in range. The best state is the lowest index with the smallest
  // metric; the strict '<' keeps the lowest index on a tie.
  always_comb begin
    all_hi = 1'b1;
    for (int i = 0; i < NS; i++)
      if (cand[i] < {1'b0, HALF}) all_hi = 1'b0;
    for (int i = 0; i < NS; i++)
      nm[i] = all_hi ? METRIC_W'(cand[i] - {1'b0, HALF}) : cand[i][METRIC_W-1:0];
    best_m   = nm[0];
    best_bit = nsv[0][TB_DEPTH-1];
    for (int i = 1; i < NS; i++)
      if (nm[i] < best_m) begin
        best_m   = nm[i];
        best_bit = nsv[i][TB_DEPTH-1];
      end
  end

  // cnt is the index of the next symbol and saturates at TB_DEPTH-1. Once
  // the survivors are full, every accepted symbol releases one decision.
  assign idx = sof ? '0 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : HALF;
      sv         <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_metric <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        pm  <= nm;
        sv  <= nsv;
        cnt <= (idx == LAST) ? LAST : idx + CW'(1);
        if (idx == LAST) begin
          out_valid  <= 1'b1;
          out_bit    <= best_bit;
          out_metric <= best_m;
        end
      end
    end
  end
endmodule

// File: tb/tb_viterbi_decoder_param.sv
module tb_viterbi_decoder_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv3, sof3, ov3, ob3;
  logic [1:0] b3, e3;
  logic [5:0] om3;
  logic       iv5, sof5, ov5, ob5;
  logic [1:0] b5, e5;
  logic [5:0] om5;

  viterbi_decoder_param u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .sof(sof3), .enc_bits(b3),
    .enc_erase(e3), .out_valid(ov3), .out_bit(ob3), .out_metric(om3));

  viterbi_decoder_param #(.K(5), .G0(5'b10011), .G1(5'b11101), .TB_DEPTH(25),
                          .METRIC_W(6)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .sof(sof5), .enc_bits(b5),
    .enc_erase(e5), .out_valid(ov5), .out_bit(ob5), .out_metric(om5));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (full-path Viterbi, plain integers) ----
  int mK, mG0, mG1, mTB, mW;
  int mpm[16];
  bit mh[16][$];
  int moff, mcnt, mnorm;

  function automatic int par(input int v);
    return $countones(v) & 1;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 16; n++) begin
      mpm[n] = (n == 0) ? 0 : (1 << (mW-1));
      mh[n].delete();
    end
    moff = 0;
    mcnt = 0;
  endtask

  task automatic m_step(input bit s, input logic [1:0] b, input logic [1:0] e,
                        output bit ev, output bit eb, output int em);
    int ns, half, best, lo;
    int npm[16];
    bit nh[16][$];
    ns = 1 << (mK-1);
    half = 1 << (mW-1);
    if (s) m_reset();
    for (int n = 0; n < ns; n++) begin
      int c[2];
      int pp[2];
      int u, sel;
      u = n >> (mK-2);
      for (int x = 0; x < 2; x++) begin
        int sr, d;
        sr = (n << 1) | x;
        pp[x] = sr % ns;
        d = 0;
        if (!e[1] && par(sr & mG0) != int'(b[1])) d++;
        if (!e[0] && par(sr & mG1) != int'(b[0])) d++;
        c[x] = mpm[pp[x]] + d;
      end
      sel = (c[1] < c[0]) ? 1 : 0;
      npm[n] = c[sel];
      nh[n] = mh[pp[sel]];
      nh[n].push_back(bit'(u));
      if (nh[n].size() > mTB) void'(nh[n].pop_front());
    end
    lo = npm[0];
    best = 0;
    for (int n = 1; n < ns; n++)
      if (npm[n] < npm[best]) best = n;
    lo = npm[best];
    if (lo - moff >= half) begin
      moff += half;
      mnorm++;
    end
    for (int n = 0; n < ns; n++) begin
      mpm[n] = npm[n];
      mh[n] = nh[n];
    end
    ev = (mcnt == mTB-1);
    eb = ev ? mh[best][0] : 1'b0;
    em = npm[best] - moff;
    if (mcnt != mTB-1) mcnt++;
  endtask

  // ---------------- drive one cycle, sample #1 after the edge -------------
  task automatic step(input int w, input bit v, input bit s, input logic [1:0] b,
                      input logic [1:0] e, output bit ov, output bit ob, output int om);
    if (w == 3) begin iv3 = v; sof3 = s; b3 = b; e3 = e; end
    else        begin iv5 = v; sof5 = s; b5 = b; e5 = e; end
    @(posedge clk);
    #1;
    if (w == 3) begin ov = ov3; ob = ob3; om = int'(om3); end
    else        begin ov = ov5; ob = ob5; om = int'(om5); end
  endtask

  // ---------------- directed table ----------------------------------------
  typedef struct {
    bit         v, s;
    logic [1:0] b, e;
    bit         ev, eb;
    int         em;
  } vec_t;
  vec_t tbl[$];

  logic [1:0] strm[21];
  bit         dec[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic add(input bit v, input bit s, input logic [1:0] b, input logic [1:0] e,
                     input bit ev, input bit eb, input int em);
    vec_t t;
    t.v = v; t.s = s; t.b = b; t.e = e; t.ev = ev; t.eb = eb; t.em = em;
    tbl.push_back(t);
  endtask

  // kind 0 clean, 1 symbol 3 flipped, 2 symbol 2 erased (plus idle cycles)
  task automatic add_frame(input int kind, input bit s0);
    for (int i = 0; i < 21; i++) begin
      logic [1:0] b, e;
      int met;
      bit ev;
      b = strm[i]; e = 2'b00; met = 0;
      if (kind == 1) begin
        met = 1;
        if (i == 3) b = 2'b11;
      end
      if (kind == 2 && i == 2) begin b = 2'b11; e = 2'b11; end
      ev = (i >= 14);
      add(1'b1, s0 && i == 0, b, e, ev, ev ? dec[ev ? i-14 : 0] : 1'b0, met);
      if (kind == 2 && i == 5) begin
        add(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 0);  // sof without in_valid is ignored
      end
    end
  endtask

  initial begin
    bit ov, ob, ev, eb;
    int om, em, k;
    logic [1:0] b, e;
    bit dq[$];

    rst_n = 1'b0;
    iv3 = 0; sof3 = 0; b3 = 0; e3 = 0;
    iv5 = 0; sof5 = 0; b5 = 0; e5 = 0;
    for (int i = 0; i < 21; i++) strm[i] = 2'b00;
    strm[0] = 2'b11; strm[1] = 2'b10; strm[2] = 2'b00; strm[3] = 2'b01;
    strm[4] = 2'b01; strm[5] = 2'b11; strm[6] = 2'b00;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", int'(ov3), 0);
    chk("rst_out_bit", int'(ob3), 0);
    chk("rst_out_metric", int'(om3), 0);
    chk("rst_out_valid_k5", int'(ov5), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frames A..E: clean, one error, erasure + idles, 10-symbol frame cut by sof, zeros
    add_frame(0, 1'b0);
    add_frame(1, 1'b1);
    add_frame(2, 1'b1);
    for (int i = 0; i < 10; i++) add(1'b1, i == 0, strm[i], 2'b00, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) add(1'b1, i == 0, 2'b00, 2'b00, i >= 14, 1'b0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(3, tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].e, ov, ob, om);
      chk($sformatf("dir_valid[%0d]", i), int'(ov), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("dir_bit[%0d]", i), int'(ob), int'(tbl[i].eb));
        chk($sformatf("dir_metric[%0d]", i), om, tbl[i].em);
      end
    end

    // ---- K=3 random data, one bit error every 20 symbols ----
    mK = 3; mG0 = 7; mG1 = 5; mTB = 15; mW = 6; mnorm = 0;
    m_reset();
    begin
      int es, u, sr;
      es = 0; k = 0;
      for (int i = 0; i < 1000; i++) begin
        u = int'($urandom & 1);
        sr = (u << 2) | es;
        es = sr >> 1;
        b = {1'(par(sr & 7)), 1'(par(sr & 5))};
        if (i % 20 == 10) b = b ^ (($urandom & 1) ? 2'b10 : 2'b01);
        dq.push_back(bit'(u));
        m_step(i == 0, b, 2'b00, ev, eb, em);
        step(3, 1'b1, i == 0, b, 2'b00, ov, ob, om);
        chk($sformatf("k3_valid[%0d]", i), int'(ov), int'(ev));
        if (ev) begin
          chk($sformatf("k3_bit_model[%0d]", i), int'(ob), int'(eb));
          chk($sformatf("k3_metric[%0d]", i), om, em);
          chk($sformatf("k3_bit_data[%0d]", i), int'(ob), int'(dq[k]));
          k++;
        end
      end
    end
    chk("k3_normalisation_seen", int'(mnorm > 0), 1);
    step(3, 1'b0, 1'b0, 2'b00, 2'b00, ov, ob, om);
    chk("k3_idle_valid", int'(ov), 0);

    // ---- K=5 random data, errors, erasures, idles, sof and a reset pulse ----
    mK = 5; mG0 = 19; mG1 = 29; mTB = 25; mW = 6; mnorm = 0;
    m_reset();
    begin
      int es, u, sr;
      bit v, s;
      es = 0;
      for (int i = 0; i < 900; i++) begin
        if (i == 400) begin
          #2 rst_n = 1'b0;
          #1;
          chk("k5_rst_valid", int'(ov5), 0);
          chk("k5_rst_bit", int'(ob5), 0);
          chk("k5_rst_metric", int'(om5), 0);
          rst_n = 1'b1;
          m_reset();
          es = 0;
        end
        s = (i == 0 || i == 250);
        v = s || i == 400 || ($urandom_range(0, 9) != 0);
        if (s) es = 0;
        ev = 1'b0; eb = 1'b0; em = 0;
        b = 2'($urandom); e = 2'b00;
        if (v) begin
          u = int'($urandom & 1);
          sr = (u << 4) | es;
          es = sr >> 1;
          b = {1'(par(sr & 19)), 1'(par(sr & 29))};
          for (int j = 0; j < 2; j++) begin
            if ($urandom_range(0, 99) < 6) b[j] = ~b[j];
            if ($urandom_range(0, 99) < 4) e[j] = 1'b1;
          end
          m_step(s, b, e, ev, eb, em);
        end
        step(5, v, s, b, e, ov, ob, om);
        chk($sformatf("k5_valid[%0d]", i), int'(ov), int'(ev));
        if (ev) begin
          chk($sformatf("k5_bit[%0d]", i), int'(ob), int'(eb));
          chk($sformatf("k5_metric[%0d]", i), om, em);
        end
      end
    end
    chk("k5_normalisation_seen", int'(mnorm > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
